// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    // Controller states; binary encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Canonical no-op instruction word (addi x0, x0, 0).
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Byte distance between consecutive instruction words.
    localparam logic [31:0] PC_STEP = 32'd4;

    // Clear the byte-offset bits so a PC always points at a whole word.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selector: start loads the reset vector, a redirect loads the
// word-aligned target, a capture advances by one word, otherwise hold.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic [31:0] i_pc,
    input  logic        i_start_load,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_capture,
    output logic [31:0] o_pc_next
);

    // Priority mux: the control inputs are mutually exclusive by
    // construction in the parent, the ordering only documents intent.
    always_comb begin
        o_pc_next = i_pc;
        if (i_start_load) begin
            o_pc_next = RESET_PC;
        end else if (i_redirect) begin
            o_pc_next = align_word(i_redirect_pc);
        end else if (i_capture) begin
            o_pc_next = i_pc + PC_STEP;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: walks the PC through an async-read
// instruction memory and hands words to decode with valid/ready flow
// control, redirects and halt.
// Optional macro FETCH_BOUNDS_CHECK_EN adds a sticky fault output raised
// when a capture is attempted at or beyond the end of the memory.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 32,
    parameter int          IDX_W    = 5,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    output logic [IDX_W-1:0]  imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              busy
`ifdef FETCH_BOUNDS_CHECK_EN
    ,
    output logic              fault
`endif
);

    // Index mask is all ones for a power-of-two DEPTH, i.e. plain truncation.
    localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(DEPTH - 1);

    fetch_state_t      r_state, w_state_next;
    logic [31:0]       r_pc, w_pc_next;
    logic              r_inst_valid, w_inst_valid_next;
    logic [DATA_W-1:0] r_inst, w_inst_next;
    logic [31:0]       r_inst_pc, w_inst_pc_next;

    logic w_start_load;
    logic w_redirect;
    logic w_accept;
    logic w_fetch_slot;
    logic w_bounds_fault;
    logic w_capture;

    assign w_start_load = (r_state == ST_IDLE) && start;
    assign w_redirect   = (r_state == ST_RUN) && redirect_valid;
    assign w_accept     = r_inst_valid && inst_ready;
    // A fetch slot exists when running, not halting/redirecting, and the
    // output register is empty or being drained this cycle.
    assign w_fetch_slot = (r_state == ST_RUN) && !halt_req && !redirect_valid &&
                          (!r_inst_valid || inst_ready);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [31:0] PC_LIMIT = 32'(DEPTH) * PC_STEP;
    logic r_fault;

    assign w_bounds_fault = w_fetch_slot && (r_pc >= PC_LIMIT);
    assign fault          = r_fault;

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_bounds_fault) begin
            r_fault <= 1'b1;
        end
    end
`else
    assign w_bounds_fault = 1'b0;
`endif

    assign w_capture = w_fetch_slot && !w_bounds_fault;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .i_pc          (r_pc),
        .i_start_load  (w_start_load),
        .i_redirect    (w_redirect),
        .i_redirect_pc (redirect_pc),
        .i_capture     (w_capture),
        .o_pc_next     (w_pc_next)
    );

    // Next-state and output-register logic; a pending word outside a fetch
    // slot simply clears once decode accepts it.
    always_comb begin
        w_state_next      = r_state;
        w_inst_valid_next = w_accept ? 1'b0 : r_inst_valid;
        w_inst_next       = r_inst;
        w_inst_pc_next    = r_inst_pc;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    w_state_next = ST_HALT;
                end
                if (redirect_valid) begin
                    w_inst_valid_next = 1'b0;
                end else if (w_capture) begin
                    w_inst_next       = imem_rdata;
                    w_inst_pc_next    = r_pc;
                    w_inst_valid_next = 1'b1;
                end else if (w_bounds_fault) begin
                    w_inst_valid_next = 1'b0;
                    w_state_next      = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!start && !halt_req) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, PC and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_inst_valid <= w_inst_valid_next;
            r_inst       <= w_inst_next;
            r_inst_pc    <= w_inst_pc_next;
        end
    end

    assign imem_addr  = r_pc[IDX_W+1:2] & IDX_MASK;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign busy       = (r_state == ST_RUN);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios followed by random
// traffic, all checked against a cycle-level model of the fetch rules.
module tb_imem_fetch_ctrl;
    import fetch_pkg::*;

    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 32;
    localparam int          IDX_W    = 5;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              halt_req = 1'b0;
    logic [IDX_W-1:0]  imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [31:0]       inst_pc;
    logic              inst_ready = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = 32'h0;
    logic              busy;
`ifdef FETCH_BOUNDS_CHECK_EN
    logic              fault;
`endif

    logic [31:0] mem [DEPTH];
    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
`ifdef FETCH_BOUNDS_CHECK_EN
        ,
        .fault          (fault)
`endif
    );

    // Reference model: 0 = idle, 1 = running, 2 = halted.
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;
    logic        m_valid;
    logic        m_fault;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void model_reset();
        m_state   = 0;
        m_pc      = RESET_PC;
        m_inst    = 32'h0;
        m_inst_pc = 32'h0;
        m_valid   = 1'b0;
        m_fault   = 1'b0;
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    function automatic void model_step();
        bit taken;
        taken = m_valid && inst_ready;
        if (!rst_n) begin
            model_reset();
        end else if (m_state == 0) begin
            if (taken) m_valid = 1'b0;
            if (start) begin
                m_state = 1;
                m_pc    = RESET_PC;
            end
        end else if (m_state == 1) begin
            if (redirect_valid) begin
                m_pc    = {redirect_pc[31:2], 2'b00};
                m_valid = 1'b0;
                if (halt_req) m_state = 2;
            end else if (halt_req) begin
                m_state = 2;
                if (taken) m_valid = 1'b0;
            end else if (!m_valid || inst_ready) begin
`ifdef FETCH_BOUNDS_CHECK_EN
                if (m_pc >= 4 * DEPTH) begin
                    m_fault = 1'b1;
                    m_valid = 1'b0;
                    m_state = 2;
                end else begin
`endif
                    m_inst    = mem[(m_pc / 4) % DEPTH];
                    m_inst_pc = m_pc;
                    m_valid   = 1'b1;
                    m_pc      = m_pc + 32'd4;
`ifdef FETCH_BOUNDS_CHECK_EN
                end
`endif
            end
        end else begin
            if (taken) m_valid = 1'b0;
            if (!start && !halt_req) m_state = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(m_valid));
        chk({tag, ".inst_pc"},    inst_pc, m_inst_pc);
        chk({tag, ".inst"},       inst, m_inst);
        chk({tag, ".imem_addr"},  32'(imem_addr), (m_pc / 4) % DEPTH);
        chk({tag, ".busy"},       32'(busy), 32'(m_state == 1));
`ifdef FETCH_BOUNDS_CHECK_EN
        chk({tag, ".fault"},      32'(fault), 32'(m_fault));
`endif
    endtask

    // One clock: edge, model update, settle, compare.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        mem[0] = INST_NOP;
        for (int i = 1; i < DEPTH; i++) mem[i] = $urandom;

        // Reset state.
        step("rst0");
        step("rst1");
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        #4;
        rst_n = 1'b1;
        step("idle");

        // Start and sequential fetch.
        start = 1'b1; inst_ready = 1'b1;
        step("start");
        chk("start_busy", 32'(busy), 32'h1);
        start = 1'b0;
        step("fetch0");
        chk("fetch0_pc", inst_pc, 32'h0);
        step("fetch1");
        chk("fetch1_pc", inst_pc, 32'h4);
        step("fetch2");
        chk("fetch2_pc", inst_pc, 32'h8);
        chk("fetch2_inst", inst, mem[2]);

        // Three-cycle stall at 0x8.
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall_pc", inst_pc, 32'h8);
            chk("stall_inst", inst, mem[2]);
        end
        inst_ready = 1'b1;
        step("resume");
        chk("resume_pc", inst_pc, 32'hC);

        // Redirect to an unaligned target.
        redirect_valid = 1'b1; redirect_pc = 32'h1E;
        step("redir");
        chk("redir_drop", 32'(inst_valid), 32'h0);
        chk("redir_addr", 32'(imem_addr), 32'd7);
        redirect_valid = 1'b0;
        step("redir_fetch");
        chk("redir_pc", inst_pc, 32'h1C);
        step("post_redir");

        // Halt and redirect together.
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        step("halt_redir");
        chk("halt_busy", 32'(busy), 32'h0);
        chk("halt_addr", 32'(imem_addr), 32'd16);
        chk("halt_valid", 32'(inst_valid), 32'h0);
        redirect_valid = 1'b0;
        step("halt_hold");
        chk("halt_hold_valid", 32'(inst_valid), 32'h0);
        halt_req = 1'b0;
        step("to_idle");

        // Run off the end of memory.
        start = 1'b1;
        step("bnd_start");
        start = 1'b0;
        for (int i = 0; i < 32; i++) step("bnd_run");
        chk("bnd_last_pc", inst_pc, 32'h7C);
        chk("bnd_wrap_addr", 32'(imem_addr), 32'h0);
        step("bnd_edge");
`ifdef FETCH_BOUNDS_CHECK_EN
        chk("bnd_fault", 32'(fault), 32'h1);
        chk("bnd_valid", 32'(inst_valid), 32'h0);
        chk("bnd_halt", 32'(busy), 32'h0);
`else
        chk("bnd_wrap_pc", inst_pc, 32'h80);
        chk("bnd_wrap_inst", inst, INST_NOP);
`endif
        halt_req = 1'b1;
        step("bnd_halt_req");
        halt_req = 1'b0;
        step("bnd_idle");

        // Reset in the middle of a stall, then restart from the vector.
        start = 1'b1;
        step("ms_start");
        start = 1'b0;
        step("ms_f0");
        step("ms_f1");
        inst_ready = 1'b0;
        step("ms_stall0");
        step("ms_stall1");
        async_reset("ms_rst");
        chk("ms_rst_valid", 32'(inst_valid), 32'h0);
        chk("ms_rst_pc", inst_pc, 32'h0);
        chk("ms_rst_inst", inst, 32'h0);
        chk("ms_rst_busy", 32'(busy), 32'h0);
        start = 1'b1; inst_ready = 1'b1;
        step("ms_restart");
        start = 1'b0;
        step("ms_refetch");
        chk("ms_refetch_pc", inst_pc, 32'h0);
        chk("ms_refetch_valid", 32'(inst_valid), 32'h1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            start          = ($urandom_range(0, 9) == 0);
            halt_req       = ($urandom_range(0, 19) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom_range(0, 160);
            inst_ready     = ($urandom_range(0, 9) < 7);
            step("rnd");
            if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
